// File: rtl/sqrt_seq_ctrl.sv
// Sequential integer square root: one sqrt_unit step per clock, SIZE/2 steps per radicand,
// with valid/ready handshakes on both sides.

module sqrt_unit #(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0] prev_num,
    input  logic [SIZE-1:0] prev_result,
    input  logic [SIZE-1:0] prev_biggest_power,
    output logic [SIZE-1:0] cur_num,
    output logic [SIZE-1:0] cur_result,
    output logic [SIZE-1:0] cur_biggest_power
);
    logic [SIZE-1:0] trial;
    logic            res_select;

    // One digit-by-digit step: subtract the trial value when it fits, then move to the next bit pair
    always_comb begin
        trial             = prev_result + prev_biggest_power;
        res_select        = prev_num >= trial;
        cur_biggest_power = prev_biggest_power >> 2;
        cur_num           = prev_num;
        cur_result        = prev_result;
        if (prev_biggest_power != '0) begin
            if (res_select) begin
                cur_num    = prev_num - trial;
                cur_result = (prev_result >> 1) + prev_biggest_power;
            end else begin
                cur_result = prev_result >> 1;
            end
        end
    end
endmodule

module sqrt_seq_ctrl #(
    parameter int unsigned SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE/2-1:0] root,
    output logic [SIZE/2:0]   remainder,
    output logic              busy
);
    localparam int unsigned ITER = SIZE / 2;
    localparam int unsigned CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [SIZE-1:0] num_q, res_q, pow_q;
    logic [SIZE-1:0] num_d, res_d, pow_d;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q, out_valid_q, busy_q;

    sqrt_unit #(.SIZE(SIZE)) u_sqrt_unit (
        .prev_num           (num_q),
        .prev_result        (res_q),
        .prev_biggest_power (pow_q),
        .cur_num            (num_d),
        .cur_result         (res_d),
        .cur_biggest_power  (pow_d)
    );

    // Handshake flags are updated together with the state so they stay Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            res_q       <= '0;
            pow_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        num_q      <= in_num;
                        res_q      <= '0;
                        pow_q      <= SIZE'(1) << (SIZE - 2);
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    num_q <= num_d;
                    res_q <= res_d;
                    pow_q <= pow_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign root      = res_q[SIZE/2-1:0];
    assign remainder = num_q[SIZE/2:0];
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: cycle-level handshake model plus floor-sqrt reference,
// directed vectors, a random sweep at SIZE=32 and an exhaustive sweep at SIZE=8.

module tb_sqrt_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [31:0] in_num;
    logic        in_ready, out_valid, busy;
    logic [15:0] root;
    logic [16:0] remainder;

    logic        in_valid8, out_ready8;
    logic [7:0]  in_num8;
    logic        in_ready8, out_valid8, busy8;
    logic [3:0]  root8;
    logic [4:0]  remainder8;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    sqrt_seq_ctrl #(.SIZE(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .out_valid(out_valid), .out_ready(out_ready), .root(root), .remainder(remainder), .busy(busy)
    );

    sqrt_seq_ctrl #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_num(in_num8),
        .out_valid(out_valid8), .out_ready(out_ready8), .root(root8), .remainder(remainder8), .busy(busy8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint isqrt(input longint n, input int bits);
        longint r = 0;
        for (int b = bits - 1; b >= 0; b--) begin
            longint t = r | (longint'(1) << b);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    // Reference model: 0 idle, 1 computing, 2 result held
    int          m_state = 0;
    int          m_cnt   = 0;
    longint      m_pend  = 0;
    logic [15:0] m_root  = '0;
    logic [16:0] m_rem   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
            m_root  = '0;
            m_rem   = '0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_pend  = longint'(in_num);
                    m_cnt   = 0;
                    m_state = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        longint r;
                        r       = isqrt(m_pend, 16);
                        m_root  = 16'(r);
                        m_rem   = 17'(m_pend - r * r);
                        m_state = 2;
                    end
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_state == 0);
            chk("out_valid", out_valid, m_state == 2);
            chk("busy", busy, m_state != 0);
            if (m_state != 1) begin
                chk("root", root, m_root);
                chk("remainder", remainder, m_rem);
            end
            if (m_state == 2) begin
                chk("num_upper_zero", dut.num_q[31:17], 0);
                chk("res_upper_zero", dut.res_q[31:16], 0);
            end
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("timeout_out_valid", 0, 1);
    endtask

    task automatic run_txn(input logic [31:0] n, input int hold, input bit pulse,
                           output logic [15:0] r, output logic [16:0] rem, output int lat);
        @(negedge clk);
        in_num    = n;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (pulse) begin
                in_valid = lat[0];
                in_num   = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("timeout_out_valid", 0, 1);
        r   = root;
        rem = remainder;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = ~i[0];
                in_num   = $urandom;
            end
            @(negedge clk);
        end
        chk("hold_root", root, r);
        chk("hold_rem", remainder, rem);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run8(input int n);
        int lat;
        longint r;
        @(negedge clk);
        in_num8    = 8'(n);
        in_valid8  = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = isqrt(longint'(n), 4);
        chk("lat8", lat, 4);
        chk("root8", root8, r);
        chk("rem8", remainder8, longint'(n) - r * r);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        logic [16:0] rem;
        int          lat;
        logic [31:0] n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_num     = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        in_num8    = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_root", root, 0);
        chk("rst_rem", remainder, 0);

        run_txn(32'd16, 0, 1'b0, r, rem, lat);
        chk("lat_16", lat, 16);
        chk("root_16", r, 4);
        chk("rem_16", rem, 0);

        run_txn(32'd17, 0, 1'b0, r, rem, lat);
        chk("root_17", r, 4);
        chk("rem_17", rem, 1);
        run_txn(32'd0, 0, 1'b0, r, rem, lat);
        chk("lat_0", lat, 16);
        chk("root_0", r, 0);
        chk("rem_0", rem, 0);

        run_txn(32'hFFFF_FFFF, 0, 1'b0, r, rem, lat);
        chk("root_max", r, 16'hFFFF);
        chk("rem_max", rem, 17'h1FFFE);

        run_txn(32'd1000, 10, 1'b1, r, rem, lat);
        chk("root_1000", r, 31);
        chk("rem_1000", rem, 39);
        chk("lat_1000", lat, 16);
        chk("idle_after_accept", in_ready, 1);

        // Accept and new request in the same cycle: only the return to idle happens
        @(negedge clk);
        in_num   = 32'd20;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("root_20", root, 4);
        chk("rem_20", remainder, 4);
        in_num    = 32'd50;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("simul_idle", in_ready, 1);
        chk("simul_no_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("simul_accept", in_ready, 0);
        wait_valid(lat);
        chk("lat_50", lat, 16);
        chk("root_50", root, 7);
        chk("rem_50", remainder, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset part-way through a computation
        @(negedge clk);
        in_num   = 32'd12345;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_root", root, 0);
        chk("abort_rem", remainder, 0);
        run_txn(32'd12345, 0, 1'b0, r, rem, lat);
        chk("root_12345", r, 111);
        chk("rem_12345", rem, 24);

        for (int i = 0; i < 1500; i++) begin
            n = $urandom;
            if (i % 5 == 0) n = n >> (i % 32);
            run_txn(n, i % 3, i[3], r, rem, lat);
            chk("rand_lat", lat, 16);
            chk("rand_root", r, isqrt(longint'(n), 16));
            chk("rand_rem", rem, longint'(n) - longint'(r) * longint'(r));
        end

        for (int v = 0; v < 256; v++) run8(v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
